hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_pkg.sv | 48 ++++
 rtl/hazard_ctrl_if.sv | 33 +++
 rtl/hazard_ctrl_shadow.sv | 27 ++
 rtl/hazard_ctrl.sv | 96 +++++++++
 tb/tb_hazard_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared RV32I opcode, writeback, forwarding and shadow slot definitions
package rv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b11;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } slot_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_S, OP_B, OP_JALR, OP_L: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_S, OP_B: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_src(input slot_t s);
        return s.valid && s.we && (s.rd != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decoder-side inputs and pipeline control outputs of the hazard unit
interface hazard_ctrl_if #(parameter int CNT_W = 32);
    logic [6:0]       opcode_D;
    logic [4:0]       rs1_D;
    logic [4:0]       rs2_D;
    logic [4:0]       rd_D;
    logic             we_reg_D;
    logic [1:0]       wb_ctrl_D;
    logic             redirect_E;
    logic             mem_busy;
    logic             stall_F;
    logic             stall_D;
    logic             stall_E;
    logic             stall_M;
    logic             flush_D;
    logic             flush_E;
    logic [1:0]       fwd_a_E;
    logic [1:0]       fwd_b_E;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output opcode_D, rs1_D, rs2_D, rd_D, we_reg_D, wb_ctrl_D, redirect_E, mem_busy,
        input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
        input  fwd_a_E, fwd_b_E, stall_cnt, flush_cnt
    );

    modport slave (
        input  opcode_D, rs1_D, rs2_D, rd_D, we_reg_D, wb_ctrl_D, redirect_E, mem_busy,
        output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
        output fwd_a_E, fwd_b_E, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_shadow.sv
// rtl/hazard_ctrl_shadow.sv - E/M/W destination shadow chain with advance, bubble and hold
module hz_shadow_pipe
    import rv_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  advance,
    input  logic  bubble,
    input  slot_t d_entry,
    output slot_t slot_e,
    output slot_t slot_m,
    output slot_t slot_w
);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_e <= '0;
            slot_m <= '0;
            slot_w <= '0;
        end else if (advance) begin
            slot_w <= slot_m;
            slot_m <= slot_e;
            slot_e <= bubble ? '0 : d_entry;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use/redirect hazard detection, stall/flush control and forwarding selects
module hazard_ctrl
    import rv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hz
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_t d_entry, slot_e, slot_m, slot_w;
    logic  use1, use2, loaduse, bubble, advance;
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    // E beats M: the younger producer holds the most recent value
    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                           input slot_t e, input slot_t m);
        if (used && is_src(e) && e.rd == rs) return FWD_M;
        if (used && is_src(m) && m.rd == rs) return FWD_W;
        return FWD_RF;
    endfunction

    always_comb begin
        d_entry.valid   = (hz.opcode_D != OP_NOP);
        d_entry.rd      = hz.rd_D;
        d_entry.we      = hz.we_reg_D;
        d_entry.is_load = (hz.wb_ctrl_D == WB_LOAD);
    end

    assign use1    = uses_rs1(hz.opcode_D);
    assign use2    = uses_rs2(hz.opcode_D);
    assign loaduse = slot_e.is_load && is_src(slot_e) &&
                     ((use1 && slot_e.rd == hz.rs1_D) || (use2 && slot_e.rd == hz.rs2_D));
    assign bubble  = hz.redirect_E || loaduse;
    assign advance = !hz.mem_busy;

    assign fwd_a_nxt = fwd_sel(use1, hz.rs1_D, slot_e, slot_m);
    assign fwd_b_nxt = fwd_sel(use2, hz.rs2_D, slot_e, slot_m);

    hz_shadow_pipe u_shadow (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .bubble  (bubble),
        .d_entry (d_entry),
        .slot_e  (slot_e),
        .slot_m  (slot_m),
        .slot_w  (slot_w)
    );

    always_comb begin
        hz.stall_F = 1'b0;
        hz.stall_D = 1'b0;
        hz.stall_E = 1'b0;
        hz.stall_M = 1'b0;
        hz.flush_D = 1'b0;
        hz.flush_E = 1'b0;
        if (rst) begin
            hz.flush_D = 1'b1;
            hz.flush_E = 1'b1;
        end else if (hz.mem_busy) begin
            hz.stall_F = 1'b1;
            hz.stall_D = 1'b1;
            hz.stall_E = 1'b1;
            hz.stall_M = 1'b1;
        end else if (hz.redirect_E) begin
            hz.flush_D = 1'b1;
            hz.flush_E = 1'b1;
        end else if (loaduse) begin
            hz.stall_F = 1'b1;
            hz.stall_D = 1'b1;
            hz.flush_E = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hz.fwd_a_E   <= FWD_RF;
            hz.fwd_b_E   <= FWD_RF;
            hz.stall_cnt <= '0;
            hz.flush_cnt <= '0;
        end else if (advance) begin
            hz.fwd_a_E <= bubble ? FWD_RF : fwd_a_nxt;
            hz.fwd_b_E <= bubble ? FWD_RF : fwd_b_nxt;
            if (hz.redirect_E) begin
                if (hz.flush_cnt != CNT_MAX) hz.flush_cnt <= hz.flush_cnt + 1'b1;
            end else if (loaduse) begin
                if (hz.stall_cnt != CNT_MAX) hz.stall_cnt <= hz.stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed and random instruction streams
module tb_hazard_ctrl;
    import rv_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hif ();
    hazard_ctrl #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .hz(hif));

    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } ins_t;

    typedef struct {
        int sf, sd, se, sm, fd, fe, fa, fb, sc, fc;
    } exp_t;

    ins_t inflight[$];     // [0]=E, [1]=M, [2]=W
    exp_t sb[$];
    int   m_fa, m_fb, m_sc, m_fc;
    int   tests = 0;
    int   fails = 0;
    bit   done = 0;

    function automatic bit reads1(logic [6:0] op);
        return op inside {OP_R, OP_I, OP_S, OP_B, OP_JALR, OP_L};
    endfunction

    function automatic bit reads2(logic [6:0] op);
        return op inside {OP_R, OP_S, OP_B};
    endfunction

    function automatic bit writes(int idx, int r);
        return inflight[idx].v && inflight[idx].we && inflight[idx].rd != 0 && inflight[idx].rd == r;
    endfunction

    function automatic int fwd_for(bit used, int r);
        if (!used) return 0;
        if (writes(0, r)) return 2;
        if (writes(1, r)) return 1;
        return 0;
    endfunction

    function automatic void model_reset();
        ins_t none = '{0, 0, 0, 0};
        inflight = {none, none, none};
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    endfunction

    task automatic chk(string name, int act, int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    task automatic cyc(bit r, bit busy, bit redir, logic [6:0] op,
                       int s1, int s2, int d, bit we, logic [1:0] wb);
        exp_t e;
        bit   u1, u2, lu, bub;
        ins_t nw;
        int   cmax = (1 << CW) - 1;
        @(posedge clk);
        #1;
        rst = r;
        hif.mem_busy = busy; hif.redirect_E = redir; hif.opcode_D = op;
        hif.rs1_D = 5'(s1); hif.rs2_D = 5'(s2); hif.rd_D = 5'(d);
        hif.we_reg_D = we; hif.wb_ctrl_D = wb;
        u1 = reads1(op);
        u2 = reads2(op);
        lu = inflight[0].ld && ((u1 && writes(0, s1)) || (u2 && writes(0, s2)));
        e = '{0, 0, 0, 0, 0, 0, m_fa, m_fb, m_sc, m_fc};
        if (r) begin
            e.fd = 1; e.fe = 1;
        end else if (busy) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1;
        end else if (redir) begin
            e.fd = 1; e.fe = 1;
        end else if (lu) begin
            e.sf = 1; e.sd = 1; e.fe = 1;
        end
        sb.push_back(e);
        if (r) begin
            model_reset();
        end else if (!busy) begin
            bub = redir || lu;
            m_fa = bub ? 0 : fwd_for(u1, s1);
            m_fb = bub ? 0 : fwd_for(u2, s2);
            if (redir) m_fc = (m_fc < cmax) ? m_fc + 1 : m_fc;
            else if (lu) m_sc = (m_sc < cmax) ? m_sc + 1 : m_sc;
            nw = bub ? '{0, 0, 0, 0} : '{op != 0, d, we, wb == 2'b01};
            inflight.push_front(nw);
            void'(inflight.pop_back());
        end
    endtask

    task automatic ins(logic [6:0] op, int s1, int s2, int d, logic [1:0] wb = 2'b00);
        cyc(0, 0, 0, op, s1, s2, d, 1, wb);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall_F", int'(hif.stall_F), e.sf);
            chk("stall_D", int'(hif.stall_D), e.sd);
            chk("stall_E", int'(hif.stall_E), e.se);
            chk("stall_M", int'(hif.stall_M), e.sm);
            chk("flush_D", int'(hif.flush_D), e.fd);
            chk("flush_E", int'(hif.flush_E), e.fe);
            chk("fwd_a_E", int'(hif.fwd_a_E), e.fa);
            chk("fwd_b_E", int'(hif.fwd_b_E), e.fb);
            chk("stall_cnt", int'(hif.stall_cnt), e.sc);
            chk("flush_cnt", int'(hif.flush_cnt), e.fc);
        end
    end

    initial begin
        logic [6:0] ops[11];
        logic [6:0] op;
        ops = '{OP_R, OP_I, OP_S, OP_B, OP_JAL, OP_JALR, OP_L, OP_AUIPC, OP_LUI, OP_NOP, 7'h7F};
        rst = 1'b1;
        hif.mem_busy = 0; hif.redirect_E = 0; hif.opcode_D = 0;
        hif.rs1_D = 0; hif.rs2_D = 0; hif.rd_D = 0; hif.we_reg_D = 0; hif.wb_ctrl_D = 0;
        model_reset();
        repeat (2) @(posedge clk);
        cyc(1, 0, 0, OP_NOP, 0, 0, 0, 0, 0);

        ins(OP_R, 2, 3, 1); ins(OP_R, 5, 6, 4); ins(OP_NOP, 0, 0, 0);
        ins(OP_I, 0, 0, 5); ins(OP_R, 5, 5, 6); ins(OP_NOP, 0, 0, 0);
        ins(OP_I, 0, 0, 5); ins(OP_R, 11, 12, 10); ins(OP_R, 5, 5, 6); ins(OP_NOP, 0, 0, 0);
        ins(OP_L, 1, 0, 7, WB_LOAD); ins(OP_R, 7, 2, 8); ins(OP_R, 7, 2, 8); ins(OP_NOP, 0, 0, 0);
        ins(OP_L, 1, 0, 0, WB_LOAD); ins(OP_R, 0, 0, 3);
        ins(OP_L, 1, 0, 9, WB_LOAD); ins(OP_LUI, 0, 0, 9); ins(OP_NOP, 0, 0, 0);
        ins(OP_L, 1, 0, 7, WB_LOAD); cyc(0, 0, 1, OP_R, 7, 2, 8, 1, 0); ins(OP_NOP, 0, 0, 0);
        ins(OP_L, 1, 0, 7, WB_LOAD);
        repeat (3) cyc(0, 1, 0, OP_R, 7, 2, 8, 1, 0);
        ins(OP_R, 7, 2, 8); ins(OP_R, 7, 2, 8);
        ins(OP_L, 1, 0, 7, WB_LOAD);
        cyc(0, 1, 0, OP_R, 7, 2, 8, 1, 0);
        cyc(1, 1, 0, OP_R, 7, 2, 8, 1, 0);
        cyc(0, 1, 0, OP_R, 7, 2, 8, 1, 0);
        ins(OP_R, 7, 2, 8); ins(OP_NOP, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, OP_NOP, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            op = ops[$urandom_range(0, 10)];
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 3) != 0, (op == OP_L) ? WB_LOAD : 2'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
